// File: rtl/led_rate_ctrl_if.sv
// rtl/led_rate_ctrl_if.sv - push-button input and rate/tick outputs of the LED rate stage
interface led_rate_ctrl_if;
    logic       Key_n;
    logic       Tick;
    logic [1:0] Rate_sel;
    logic       Key_press;
    logic       Led_out;

    modport master (
        output Key_n,
        input  Tick,
        input  Rate_sel,
        input  Key_press,
        input  Led_out
    );

    modport slave (
        input  Key_n,
        output Tick,
        output Rate_sel,
        output Key_press,
        output Led_out
    );
endinterface

// File: rtl/led_rate_ctrl.sv
// rtl/led_rate_ctrl.sv - debounced button steps a 4-entry blink rate and emits a half-period Tick
module led_rate_ctrl #(
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd540_000,
    parameter logic [23:0] HALF_PERIOD_0   = 24'd13_499_999,
    parameter logic [23:0] HALF_PERIOD_1   = 24'd6_749_999,
    parameter logic [23:0] HALF_PERIOD_2   = 24'd3_374_999,
    parameter logic [23:0] HALF_PERIOD_3   = 24'd1_687_499
) (
    input  logic             Clock,
    input  logic             Reset_n,
    led_rate_ctrl_if.slave   io
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    deb_state_t  state, state_nxt;
    logic [23:0] dcnt, dcnt_nxt;
    logic [23:0] hcnt;
    logic [23:0] limit;
    logic        key_s1, key_s2;
    logic        press_evt;
    logic        tick_q, press_q, led_q;
    logic [1:0]  rate_q;

    // Synchronizer flops reset to the released level so reset never looks like a press.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            state  <= IDLE;
            dcnt   <= 24'd0;
        end else begin
            key_s1 <= io.Key_n;
            key_s2 <= key_s1;
            state  <= state_nxt;
            dcnt   <= dcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        press_evt = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s2) begin
                    state_nxt = PRESS_WAIT;
                    dcnt_nxt  = 24'd0;
                end
            end
            PRESS_WAIT: begin
                if (key_s2) begin
                    state_nxt = IDLE;
                    dcnt_nxt  = 24'd0;
                end else if (dcnt == DEBOUNCE_CYCLES - 24'd1) begin
                    state_nxt = PRESSED;
                    dcnt_nxt  = 24'd0;
                    press_evt = 1'b1;
                end else begin
                    dcnt_nxt  = dcnt + 24'd1;
                end
            end
            PRESSED: begin
                if (key_s2) begin
                    state_nxt = RELEASE_WAIT;
                    dcnt_nxt  = 24'd0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back low returns to PRESSED silently; only PRESS_WAIT can pulse.
                if (!key_s2) begin
                    state_nxt = PRESSED;
                    dcnt_nxt  = 24'd0;
                end else if (dcnt == DEBOUNCE_CYCLES - 24'd1) begin
                    state_nxt = IDLE;
                    dcnt_nxt  = 24'd0;
                end else begin
                    dcnt_nxt  = dcnt + 24'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                dcnt_nxt  = 24'd0;
            end
        endcase
    end

    always_comb begin
        limit = HALF_PERIOD_0;
        case (rate_q)
            2'd0:    limit = HALF_PERIOD_0;
            2'd1:    limit = HALF_PERIOD_1;
            2'd2:    limit = HALF_PERIOD_2;
            default: limit = HALF_PERIOD_3;
        endcase
    end

    // A press overrides a coincident terminal count so the new rate starts a full half-period.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            hcnt    <= 24'd0;
            tick_q  <= 1'b0;
            led_q   <= 1'b0;
            rate_q  <= 2'd0;
            press_q <= 1'b0;
        end else begin
            press_q <= press_evt;
            if (press_evt) begin
                rate_q <= rate_q + 2'd1;
                hcnt   <= 24'd0;
                tick_q <= 1'b0;
            end else if (hcnt < limit) begin
                hcnt   <= hcnt + 24'd1;
                tick_q <= 1'b0;
            end else begin
                hcnt   <= 24'd0;
                tick_q <= 1'b1;
                led_q  <= ~led_q;
            end
        end
    end

    assign io.Tick      = tick_q;
    assign io.Rate_sel  = rate_q;
    assign io.Key_press = press_q;
    assign io.Led_out   = led_q;

endmodule
